// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns (bit 6 = g ... bit 0 = a),
// special digit codes and the scan sample layout used by the reader.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   // Alternate glyphs some drivers emit: 6 without top bar, 7 with hook, 9 without tail.
   localparam logic [6:0] SEG_6_ALT = 7'h7C;
   localparam logic [6:0] SEG_7_ALT = 7'h27;
   localparam logic [6:0] SEG_9_ALT = 7'h67;

   localparam logic [6:0] SEG_BLANK   = 7'h00;
   localparam logic [3:0] DIGIT_BLANK = 4'hF;
   localparam logic [3:0] DIGIT_ERR   = 4'hE;

   typedef struct packed {
      logic [NUM_DIGITS-1:0] sel;
      logic [6:0]            seg;
   } scan_sample_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to BCD digit decoder; unknown patterns
// map to DIGIT_ERR with err set, a blank display maps to DIGIT_BLANK.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       err
);

   always_comb begin
      digit = DIGIT_ERR;
      case (seg)
         SEG_0:                digit = 4'd0;
         SEG_1:                digit = 4'd1;
         SEG_2:                digit = 4'd2;
         SEG_3:                digit = 4'd3;
         SEG_4:                digit = 4'd4;
         SEG_5:                digit = 4'd5;
         SEG_6, SEG_6_ALT:     digit = 4'd6;
         SEG_7, SEG_7_ALT:     digit = 4'd7;
         SEG_8:                digit = 4'd8;
         SEG_9, SEG_9_ALT:     digit = 4'd9;
         SEG_BLANK:            digit = DIGIT_BLANK;
         default:              digit = DIGIT_ERR;
      endcase
      err = (digit == DIGIT_ERR);
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 4-digit seven-segment display: debounces each scan slot,
// collects a full frame of digits and hands it off over a valid/ready port.
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   sel,
   output logic [4*NUM_DIGITS-1:0] out_bcd,
   output logic [NUM_DIGITS-1:0]   out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);

   localparam logic [7:0] COMMIT_AT = 8'(STABLE_CYCLES - 1);

   scan_sample_t              samp_p0, samp_p1;
   logic [7:0]                stab_cnt, cnt_now;
   logic                      sel_ok, commit, frame_done;
   logic [3:0]                dec_digit;
   logic                      dec_err;
   logic [NUM_DIGITS-1:0]     seen, slot_err;
   logic [4*NUM_DIGITS-1:0]   slot_bcd;

   seg7_pattern_decode u_decode (
      .seg   (samp_p0.seg),
      .digit (dec_digit),
      .err   (dec_err)
   );

   // Stage p0 -> p1: stability of the registered sample against its predecessor.
   always_comb begin
      sel_ok  = $onehot(samp_p0.sel);
      cnt_now = 8'd0;
      if (sel_ok && (samp_p0 == samp_p1))
         cnt_now = (stab_cnt == 8'hFF) ? stab_cnt : stab_cnt + 8'd1;
      commit     = sel_ok && (cnt_now == COMMIT_AT);
      frame_done = &seen;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         samp_p0   <= '0;
         samp_p1   <= '0;
         stab_cnt  <= 8'd0;
         seen      <= '0;
         out_bcd   <= '0;
         out_err   <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         samp_p0  <= {sel, seg};
         samp_p1  <= samp_p0;
         stab_cnt <= cnt_now;
         // A commit landing in the completion cycle belongs to the next frame.
         seen     <= (frame_done ? '0 : seen) | (commit ? samp_p0.sel : '0);

         if (frame_done) begin
            if (out_valid && !out_ready) begin
               overrun <= 1'b1;
            end else begin
               out_bcd   <= slot_bcd;
               out_err   <= slot_err;
               out_valid <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Slot contents are qualified by seen, so they need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (commit && samp_p0.sel[i]) begin
            slot_bcd[4*i +: 4] <= dec_digit;
            slot_err[i]        <= dec_err;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed-vector bench for seg7_scan_reader with a queue-based scoreboard
// checked by an independent output monitor.
module tb_seg7_scan_reader;
   import seg7_pkg::*;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg = 7'h00;
   logic [3:0]  sel = 4'h0;
   logic [15:0] out_bcd;
   logic [3:0]  out_err;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        overrun;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  err;
   } frame_t;
   frame_t sb[$];

   always #5 clk = ~clk;

   seg7_scan_reader #(.STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg       (seg),
      .sel       (sel),
      .out_bcd   (out_bcd),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every completed transfer must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_frame: got bcd %h err %b, expected no frame", out_bcd, out_err);
         end else begin
            frame_t f;
            f = sb.pop_front();
            check("frame_bcd", {16'h0, out_bcd}, {16'h0, f.bcd});
            check("frame_err", {28'h0, out_err}, {28'h0, f.err});
         end
      end
   end

   // Hold sel/seg for n cycles; starts and ends just after a rising edge.
   task automatic present(input logic [3:0] s, input logic [6:0] g, input int n, input bit chk_idle);
      sel = s;
      seg = g;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (chk_idle) check("no_valid", {31'h0, out_valid}, 32'h0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset values
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_bcd", {16'h0, out_bcd}, 32'h0);
      check("rst_err", {28'h0, out_err}, 32'h0);
      check("rst_overrun", {31'h0, overrun}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic capture with latency check on the final digit
      sb.push_back('{bcd: 16'h0123, err: 4'h0});
      present(4'b0001, SEG_3, 6, 1'b0);
      present(4'b0010, SEG_2, 6, 1'b0);
      present(4'b0100, SEG_1, 6, 1'b0);
      sel = 4'b1000;
      seg = SEG_0;
      for (int k = 0; k <= S + 2; k++) begin
         @(negedge clk);
         if (k == S + 1) check("latency_early", {31'h0, out_valid}, 32'h0);
         if (k == S + 2) check("latency_valid", {31'h0, out_valid}, 32'h1);
         @(posedge clk);
         #1;
      end
      present(4'b0000, SEG_BLANK, 3, 1'b0);

      // Glitch rejection on slot 0, then fill the others: no frame may appear
      for (int i = 0; i < 5; i++) begin
         present(4'b0001, SEG_1, 2, 1'b1);
         present(4'b0001, SEG_2, 2, 1'b1);
      end
      present(4'b0010, SEG_5, 6, 1'b1);
      present(4'b0100, SEG_4, 6, 1'b1);
      present(4'b1000, SEG_6, 6, 1'b1);
      sb.push_back('{bcd: 16'h6453, err: 4'h0});
      present(4'b0001, SEG_3, 8, 1'b0);
      present(4'b0000, SEG_BLANK, 3, 1'b0);

      // Decode edge cases: alt 6, blank, unknown, alt 7
      sb.push_back('{bcd: 16'h7EF6, err: 4'b0100});
      present(4'b0001, 7'h7C, 6, 1'b0);
      present(4'b0010, 7'h00, 6, 1'b0);
      present(4'b0100, 7'h49, 6, 1'b0);
      present(4'b1000, 7'h27, 8, 1'b0);
      present(4'b0000, SEG_BLANK, 3, 1'b0);

      // Backpressure: second frame is dropped and flagged
      out_ready = 1'b0;
      sb.push_back('{bcd: 16'h1111, err: 4'h0});
      for (int i = 0; i < 4; i++) present(4'(1 << i), SEG_1, 6, 1'b0);
      @(negedge clk);
      check("bp_first_valid", {31'h0, out_valid}, 32'h1);
      check("bp_no_overrun_yet", {31'h0, overrun}, 32'h0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) present(4'(1 << i), SEG_2, 6, 1'b0);
      present(4'b0000, SEG_BLANK, 3, 1'b0);
      @(negedge clk);
      check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      check("bp_hold_bcd", {16'h0, out_bcd}, 32'h1111);
      check("bp_hold_err", {28'h0, out_err}, 32'h0);
      check("bp_overrun", {31'h0, overrun}, 32'h1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      present(4'b0000, SEG_BLANK, 4, 1'b0);
      @(negedge clk);
      check("bp_drained", {31'h0, out_valid}, 32'h0);
      @(posedge clk);
      #1;

      // Bad select: slots 2 and 3 filled, so any stray commit into 0/1 completes a frame
      present(4'b0100, SEG_0, 6, 1'b0);
      present(4'b1000, SEG_0, 6, 1'b0);
      present(4'b0000, SEG_0, 10, 1'b1);
      present(4'b0011, SEG_1, 10, 1'b1);
      sb.push_back('{bcd: 16'h0020, err: 4'h0});
      present(4'b0001, SEG_0, 6, 1'b0);
      present(4'b0010, SEG_2, 8, 1'b0);
      present(4'b0000, SEG_BLANK, 3, 1'b0);

      // Reset mid-frame discards partial slots
      present(4'b0001, SEG_1, 6, 1'b0);
      present(4'b0010, SEG_1, 6, 1'b0);
      present(4'b0100, SEG_1, 6, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_bcd", {16'h0, out_bcd}, 32'h0);
      check("mid_rst_overrun", {31'h0, overrun}, 32'h0);
      check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
      @(posedge clk);
      #1;
      present(4'b1000, SEG_1, 10, 1'b1);
      @(negedge clk);
      check("post_rst_bcd", {16'h0, out_bcd}, 32'h0);
      check("post_rst_err", {28'h0, out_err}, 32'h0);
      check("post_rst_overrun", {31'h0, overrun}, 32'h0);

      check("scoreboard_drained", sb.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
